// File: rtl/fx_bus_pkg.sv
// Shared constants and state encoding for the fx register-bus arbiter.
package fx_bus_pkg;

  localparam int unsigned FX_AW       = 22;
  localparam int unsigned FX_DW       = 8;
  localparam int unsigned DEV_ID_MSB  = 21;
  localparam int unsigned DEV_ID_LSB  = 16;
  localparam int unsigned FX_RD_LAT   = 1;
  localparam int unsigned FX_CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fx_state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fx_rr_arb.sv
// Combinational round-robin pick: the first pending requester at or after i_ptr wins.
module fx_rr_arb
  import fx_bus_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic w_found;

  // Walk distances from the pointer; the smallest distance with a request wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!w_found && i_req[i] && (((i + N_REQ - 32'(i_ptr)) % N_REQ) == k)) begin
          o_gnt[i] = 1'b1;
          o_idx    = IW'(i);
          w_found  = 1'b1;
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fx_bus_arb.sv
// Round-robin arbiter and single-transaction sequencer for the shared fx register bus.
module fx_bus_arb
  import fx_bus_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned AW     = FX_AW,
  parameter int unsigned DW     = FX_DW,
  parameter int unsigned RD_LAT = FX_RD_LAT
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_vld,
  input  logic [N_REQ-1:0]  req_wr,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]  req_ack,
  output logic [DW-1:0]     req_rdata,
  output logic [AW-1:0]     fx_waddr,
  output logic [DW-1:0]     fx_data,
  output logic              fx_wr,
  output logic [AW-1:0]     fx_raddr,
  output logic              fx_rd,
  input  logic [DW-1:0]     fx_q,
  output logic              busy
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned CW = FX_CNT_W;

  fx_state_e        r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]    r_gidx, w_gidx_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [DW-1:0]    r_rdata, w_rdata_nxt;
  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  logic             r_fx_wr, w_fx_wr_nxt;
  logic             r_fx_rd, w_fx_rd_nxt;
  logic [AW-1:0]    r_fx_waddr, w_fx_waddr_nxt;
  logic [AW-1:0]    r_fx_raddr, w_fx_raddr_nxt;
  logic [DW-1:0]    r_fx_data, w_fx_data_nxt;
  logic             r_busy, w_busy_nxt;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_sel_wr;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;

  fx_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .i_req (req_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // One-hot mux of the picked requester's payload.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_sel_wr    = w_sel_wr | req_wr[i];
        w_sel_addr  = w_sel_addr | req_addr[i*AW +: AW];
        w_sel_wdata = w_sel_wdata | req_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; fx outputs are non-zero only for the ISSUE cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gidx_nxt     = r_gidx;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_rdata_nxt    = r_rdata;
    w_ack_nxt      = '0;
    w_fx_wr_nxt    = 1'b0;
    w_fx_rd_nxt    = 1'b0;
    w_fx_waddr_nxt = '0;
    w_fx_raddr_nxt = '0;
    w_fx_data_nxt  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt   = w_pick_gnt;
          w_gidx_nxt  = w_pick_idx;
          w_rdata_nxt = '0;
          w_state_nxt = ST_ISSUE;
          if (w_sel_wr) begin
            w_fx_wr_nxt    = 1'b1;
            w_fx_waddr_nxt = w_sel_addr;
            w_fx_data_nxt  = w_sel_wdata;
          end else begin
            w_fx_rd_nxt    = 1'b1;
            w_fx_raddr_nxt = w_sel_addr;
          end
        end
      end
      ST_ISSUE: begin
        if (r_fx_wr) begin
          w_ack_nxt   = r_gnt;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = CW'(RD_LAT - 1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_rdata_nxt = fx_q;
          w_ack_nxt   = r_gnt;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_DONE: begin
        w_ptr_nxt   = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + IW'(1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_ack      <= '0;
      r_fx_wr    <= 1'b0;
      r_fx_rd    <= 1'b0;
      r_fx_waddr <= '0;
      r_fx_raddr <= '0;
      r_fx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gidx     <= w_gidx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rdata    <= w_rdata_nxt;
      r_ack      <= w_ack_nxt;
      r_fx_wr    <= w_fx_wr_nxt;
      r_fx_rd    <= w_fx_rd_nxt;
      r_fx_waddr <= w_fx_waddr_nxt;
      r_fx_raddr <= w_fx_raddr_nxt;
      r_fx_data  <= w_fx_data_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign req_ack   = r_ack;
  assign req_rdata = r_rdata;
  assign fx_waddr  = r_fx_waddr;
  assign fx_data   = r_fx_data;
  assign fx_wr     = r_fx_wr;
  assign fx_raddr  = r_fx_raddr;
  assign fx_rd     = r_fx_rd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Bench for fx_bus_arb: two instances (read latency 1 and 3) against a transaction-level model.
module tb_fx_bus_arb;

  localparam int N  = 2;
  localparam int AW = 22;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    vld   [2];
  logic [N-1:0]    wr    [2];
  logic [N*AW-1:0] addr  [2];
  logic [N*DW-1:0] wdata [2];
  logic [N-1:0]    ack   [2];
  logic [DW-1:0]   rdata [2];
  logic [AW-1:0]   waddr [2];
  logic [AW-1:0]   raddr [2];
  logic [DW-1:0]   fdata [2];
  logic [DW-1:0]   fq    [2];
  logic            fwr   [2];
  logic            frd   [2];
  logic            busy  [2];
  logic            garb  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mptr  [2];
  logic [7:0] mmem [2][256];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int unsigned LAT = (gi == 0) ? 1 : 3;
    logic [7:0]    pipe;
    logic [AW-1:0] ra;
    logic [7:0]    smem [256];

    fx_bus_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clk_sys  (clk),
      .rst_n    (rst_n),
      .req_vld  (vld[gi]),
      .req_wr   (wr[gi]),
      .req_addr (addr[gi]),
      .req_wdata(wdata[gi]),
      .req_ack  (ack[gi]),
      .req_rdata(rdata[gi]),
      .fx_waddr (waddr[gi]),
      .fx_data  (fdata[gi]),
      .fx_wr    (fwr[gi]),
      .fx_raddr (raddr[gi]),
      .fx_rd    (frd[gi]),
      .fx_q     (fq[gi]),
      .busy     (busy[gi])
    );

    // Slave on dev_id 0x01 only: data appears LAT cycles after the read strobe.
    initial begin
      pipe = '0;
      ra   = '0;
      for (int i = 0; i < 256; i++) smem[i] = 8'(i);
    end
    always @(posedge clk) begin
      pipe <= {pipe[6:0], frd[gi]};
      if (frd[gi]) ra <= raddr[gi];
      if (fwr[gi] && waddr[gi][21:16] == 6'h01) smem[waddr[gi][7:0]] <= fdata[gi];
    end
    assign fq[gi] = pipe[LAT-1] ? ((ra[21:16] == 6'h01) ? smem[ra[7:0]] : 8'h00)
                  : (garb[gi] && (pipe[0] | pipe[1])) ? 8'hFF : 8'h00;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_ctl"}, 64'({ack[d], rdata[d], fdata[d], fwr[d], frd[d], busy[d]}), 64'd0);
    chk({tag, "_adr"}, 64'({waddr[d], raddr[d]}), 64'd0);
  endtask

  function automatic logic [7:0] mread(input int d, input logic [AW-1:0] a);
    return (a[21:16] == 6'h01) ? mmem[d][a[7:0]] : 8'h00;
  endfunction

  task automatic newreq(input int d, input int i);
    wr[d][i] = 1'($urandom);
    addr[d][i*AW +: AW] = {($urandom_range(0, 3) == 0) ? 6'h02 : 6'h01, 8'h00, 8'($urandom)};
    wdata[d][i*DW +: DW] = 8'($urandom);
    vld[d][i] = 1'b1;
  endtask

  // Runs one transaction from its IDLE cycle; returns in the ack cycle.
  task automatic txn(input int d, output int g, output logic [7:0] rd, output int scyc, output int lat_o);
    int lat, c0;
    logic ew;
    logic [AW-1:0] ea;
    logic [7:0] ed, erd;
    lat = (d == 0) ? 1 : 3;
    c0  = cyc;
    g   = 0;
    for (int k = N - 1; k >= 0; k--)
      if (vld[d][(mptr[d] + k) % N]) g = (mptr[d] + k) % N;
    ew = wr[d][g];
    ea = addr[d][g*AW +: AW];
    ed = wdata[d][g*DW +: DW];
    chk("idle_busy", 64'(busy[d]), 64'd0);
    step();
    scyc = cyc;
    chk("wr_strobe", 64'(fwr[d]), 64'(ew));
    chk("rd_strobe", 64'(frd[d]), 64'(!ew));
    chk("waddr", 64'(waddr[d]), ew ? 64'(ea) : 64'd0);
    chk("wdata", 64'(fdata[d]), ew ? 64'(ed) : 64'd0);
    chk("raddr", 64'(raddr[d]), ew ? 64'd0 : 64'(ea));
    chk("issue_busy_ack", 64'({busy[d], ack[d]}), 64'({1'b1, 2'b00}));
    if (!ew) begin
      for (int k = 0; k < lat; k++) begin
        step();
        chk("wait_quiet", 64'({fwr[d], frd[d], ack[d], waddr[d], raddr[d]}), 64'd0);
        chk("wait_busy", 64'(busy[d]), 64'd1);
      end
    end
    erd = ew ? 8'h00 : mread(d, ea);
    if (ew && ea[21:16] == 6'h01) mmem[d][ea[7:0]] = ed;
    step();
    chk("ack", 64'(ack[d]), 64'(2'b01 << g));
    chk("rdata", 64'(rdata[d]), 64'(erd));
    chk("done_quiet", 64'({fwr[d], frd[d]}), 64'd0);
    chk("done_busy", 64'(busy[d]), 64'd1);
    rd      = rdata[d];
    lat_o   = cyc - c0;
    mptr[d] = (g + 1) % N;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    mptr[0] = 0;
    mptr[1] = 0;
  endtask

  initial begin
    int g, sc, lat;
    int scs [3];
    logic [7:0] rd;

    for (int d = 0; d < 2; d++) begin
      vld[d] = '0; wr[d] = '0; addr[d] = '0; wdata[d] = '0; garb[d] = 1'b0;
      mptr[d] = 0;
      for (int i = 0; i < 256; i++) mmem[d][i] = 8'(i);
    end
    rst_n = 1'b0;
    step();
    step();
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst_n = 1'b1;

    // Single write
    vld[0] = 2'b01; wr[0] = 2'b01;
    addr[0][0 +: AW] = 22'h010040; wdata[0][0 +: DW] = 8'h05;
    txn(0, g, rd, sc, lat);
    chk("t1_grant", 64'(g), 64'd0);
    chk("t1_lat", 64'(lat), 64'd2);
    vld[0] = '0;
    step();

    // Single read, latency 1
    vld[0] = 2'b10; wr[0] = 2'b00; addr[0][AW +: AW] = 22'h010080;
    txn(0, g, rd, sc, lat);
    chk("t2_grant", 64'(g), 64'd1);
    chk("t2_rdata", 64'(rd), 64'h80);
    chk("t2_lat", 64'(lat), 64'd3);
    vld[0] = '0;
    step();

    // Contention after reset: strict alternation
    do_reset();
    vld[0] = 2'b11; wr[0] = 2'b11;
    addr[0] = {22'h010021, 22'h010020}; wdata[0] = {8'hB1, 8'hA0};
    for (int k = 0; k < 4; k++) begin
      txn(0, g, rd, sc, lat);
      chk("t3_order", 64'(g), 64'(k % 2));
      newreq(0, g);
      wr[0][g] = 1'b1;
      step();
    end
    vld[0] = '0;
    step();

    // Read latency 3 with garbage on the ignored WAIT cycles
    garb[1] = 1'b1;
    vld[1] = 2'b01; wr[1] = 2'b00; addr[1][0 +: AW] = 22'h01005A;
    txn(1, g, rd, sc, lat);
    chk("t4_rdata", 64'(rd), 64'h5A);
    chk("t4_lat", 64'(lat), 64'd5);
    garb[1] = 1'b0;
    vld[1] = '0;
    step();

    // Reset in WAIT: abandon, no ack, pointer back to requester 0
    vld[1] = 2'b10; wr[1] = 2'b00; addr[1][AW +: AW] = 22'h010011;
    step();
    chk("t5_issue_rd", 64'(frd[1]), 64'd1);
    step();
    chk("t5_wait_busy", 64'(busy[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero(1, "t5_async1");
    chk_zero(0, "t5_async0");
    vld[1] = 2'b11; wr[1] = 2'b11;
    addr[1] = {22'h010031, 22'h010030}; wdata[1] = {8'h31, 8'h30};
    mptr[0] = 0;
    mptr[1] = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_ack", 64'({ack[1], busy[1]}), 64'd0);
    end
    rst_n = 1'b1;
    txn(1, g, rd, sc, lat);
    chk("t5_first", 64'(g), 64'd0);
    vld[1][0] = 1'b0;
    step();
    txn(1, g, rd, sc, lat);
    chk("t5_second", 64'(g), 64'd1);
    vld[1] = '0;
    step();

    // Back-to-back writes from requester 0
    vld[0] = 2'b01; wr[0] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      addr[0][0 +: AW] = 22'(22'h010010 + k);
      wdata[0][0 +: DW] = 8'(8'hC0 + k);
      txn(0, g, rd, scs[k], lat);
      if (k == 2) vld[0] = '0;
      step();
    end
    chk("t6_gap1", 64'(scs[1] - scs[0]), 64'd3);
    chk("t6_gap2", 64'(scs[2] - scs[1]), 64'd3);

    // Randomized traffic on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 30; t++) begin
        if (vld[d] == '0)
          for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) newreq(d, i);
        if (vld[d] == '0) newreq(d, int'($urandom_range(0, N - 1)));
        txn(d, g, rd, sc, lat);
        if ($urandom_range(0, 1) == 1) newreq(d, g);
        else vld[d][g] = 1'b0;
        step();
      end
      vld[d] = '0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
